// File: rtl/riscv_mem_pkg.sv
// Shared MEM-stage definitions for the load extension and the store write buffer.
// Funct3 and opcode constants, plus the store buffer entry layout.
package riscv_mem_pkg;

    localparam int XLEN  = 32;
    localparam int NLANE = 4;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0]  waddr;
        logic [XLEN-1:0]  wdata;
        logic [NLANE-1:0] wstrb;
    } swb_entry_t;

endpackage

// File: rtl/store_write_buffer_formatter.sv
// Store formatter: lane-replicates rs2 and builds byte strobes for SB/SH/SW.
// MISALIGN_CHECK_EN adds the misaligned flag output.
module store_formatter
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_a,
    input  logic [31:0] i_rs2,
    output logic [31:0] o_data,
    output logic [3:0]  o_strb,
    output logic        o_illegal
`ifdef MISALIGN_CHECK_EN
    ,
    output logic        o_misaligned
`endif
);

    always_comb begin
        o_data    = '0;
        o_strb    = '0;
        o_illegal = 1'b0;
        unique case (1'b1)
            (i_funct3 == F3_SB): begin
                o_data = {4{i_rs2[7:0]}};
                o_strb = 4'b0001 << i_a;
            end
            (i_funct3 == F3_SH): begin
                o_data = {2{i_rs2[15:0]}};
                o_strb = 4'b0011 << {i_a[1], 1'b0};
            end
            (i_funct3 == F3_SW): begin
                o_data = i_rs2;
                o_strb = 4'b1111;
            end
            default: o_illegal = 1'b1;
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    assign o_misaligned = ((i_funct3 == F3_SH) && i_a[0])
                        || ((i_funct3 == F3_SW) && (i_a != 2'b00));
`endif

endmodule

// File: rtl/store_write_buffer.sv
// MEM-stage store write buffer: formats stores, queues them, drains to memory.
// Optional MISALIGN_CHECK_EN adds misaligned_M and drops misaligned stores.
module store_write_buffer
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int FUNCT3_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      store_valid_M,
    input  logic                      load_valid_M,
    input  logic [FUNCT3_WIDTH-1:0]   funct3_M,
    input  logic [ADDR_WIDTH-1:0]     addr_M,
    input  logic [DATA_WIDTH-1:0]     wdata_M,
    output logic                      stall_M,
    output logic                      illegal_store_M,
`ifdef MISALIGN_CHECK_EN
    output logic                      misaligned_M,
`endif
    output logic                      mem_wvalid,
    output logic [ADDR_WIDTH-1:0]     mem_waddr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [3:0]                mem_wstrb,
    input  logic                      mem_wready,
    output logic [$clog2(DEPTH):0]    buf_count,
    output logic                      buf_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    swb_entry_t       r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_count;

    logic [31:0]      w_fdata;
    logic [3:0]       w_fstrb;
    logic             w_illegal;
    logic             w_reject;
    logic             w_full;
    logic             w_deq;
    logic             w_enq;
    logic             w_hit;
    swb_entry_t       w_new;

    store_formatter u_fmt (
        .i_funct3     (funct3_M),
        .i_a          (addr_M[1:0]),
        .i_rs2        (wdata_M),
        .o_data       (w_fdata),
        .o_strb       (w_fstrb),
`ifdef MISALIGN_CHECK_EN
        .o_misaligned (w_reject),
`endif
        .o_illegal    (w_illegal)
    );

`ifdef MISALIGN_CHECK_EN
    assign misaligned_M = store_valid_M && w_reject;
`else
    assign w_reject = 1'b0;
`endif

    assign illegal_store_M = store_valid_M && w_illegal;

    assign buf_count  = r_count;
    assign buf_empty  = (r_count == '0);
    assign mem_wvalid = !buf_empty;
    assign mem_waddr  = r_mem[r_rd].waddr;
    assign mem_wdata  = r_mem[r_rd].wdata;
    assign mem_wstrb  = r_mem[r_rd].wstrb;

    assign w_full = (r_count == CW'(DEPTH));
    assign w_deq  = mem_wvalid && mem_wready;

    // A load stalls while any occupied slot holds its word; no forwarding.
    always_comb begin : hazard_scan
        logic [PW-1:0] idx;
        idx   = r_rd;
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rd + PW'(i);
            if ((CW'(i) < r_count)
                && (r_mem[idx].waddr[ADDR_WIDTH-1:2]
                    == addr_M[ADDR_WIDTH-1:2])) begin
                w_hit = 1'b1;
            end
        end
    end

    assign stall_M = (store_valid_M && w_full && !w_deq)
                   || (load_valid_M && w_hit);

    assign w_enq = store_valid_M && !stall_M
                 && !w_illegal && !w_reject;

    always_comb begin
        w_new       = '0;
        w_new.waddr = {addr_M[ADDR_WIDTH-1:2], 2'b00};
        w_new.wdata = w_fdata;
        w_new.wstrb = w_fstrb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_wr] <= w_new;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_deq) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: queue-based reference model plus directed vectors.
// Define MISALIGN_CHECK_EN to also exercise misaligned_M.
module tb_store_write_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        store_valid_M = 1'b0;
    logic        load_valid_M = 1'b0;
    logic [2:0]  funct3_M = '0;
    logic [31:0] addr_M = '0;
    logic [31:0] wdata_M = '0;
    logic        stall_M;
    logic        illegal_store_M;
    logic        misaligned_M;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_wready = 1'b0;
    logic [2:0]  buf_count;
    logic        buf_empty;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;

    ent_t q[$];

    store_write_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .store_valid_M   (store_valid_M),
        .load_valid_M    (load_valid_M),
        .funct3_M        (funct3_M),
        .addr_M          (addr_M),
        .wdata_M         (wdata_M),
        .stall_M         (stall_M),
        .illegal_store_M (illegal_store_M),
`ifdef MISALIGN_CHECK_EN
        .misaligned_M    (misaligned_M),
`endif
        .mem_wvalid      (mem_wvalid),
        .mem_waddr       (mem_waddr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_wready      (mem_wready),
        .buf_count       (buf_count),
        .buf_empty       (buf_empty)
    );

`ifndef MISALIGN_CHECK_EN
    assign misaligned_M = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: what the buffer must do given the queue and current inputs.
    function automatic void model(output bit stall, output bit enq,
                                  output bit deq, output bit ill,
                                  output bit mis, output ent_t e);
        bit legal;
        bit full;
        bit hz;
        e.a   = {addr_M[31:2], 2'b00};
        e.d   = 32'h0;
        e.s   = 4'h0;
        legal = 1'b1;
        case (funct3_M)
            3'd0: begin
                e.d = {24'h0, wdata_M[7:0]} * 32'h01010101;
                e.s = 4'(1 << addr_M[1:0]);
            end
            3'd1: begin
                e.d = {16'h0, wdata_M[15:0]} * 32'h00010001;
                e.s = 4'(3 << (addr_M[1:0] & 2'b10));
            end
            3'd2: begin
                e.d = wdata_M;
                e.s = 4'hF;
            end
            default: legal = 1'b0;
        endcase
        mis = (funct3_M == 3'd1 && addr_M[0])
           || (funct3_M == 3'd2 && addr_M[1:0] != 2'b00);
`ifdef MISALIGN_CHECK_EN
        if (mis) legal = 1'b0;
`endif
        ill  = store_valid_M && (funct3_M > 3'd2);
        full = (q.size() == 4);
        deq  = (q.size() > 0) && mem_wready;
        hz   = 1'b0;
        foreach (q[i]) if (q[i].a[31:2] == addr_M[31:2]) hz = 1'b1;
        stall = (store_valid_M && full && !deq) || (load_valid_M && hz);
        enq   = store_valid_M && !stall && legal;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit st, en, dq, il, ms;
        ent_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            model(st, en, dq, il, ms, e);
            if (dq) void'(q.pop_front());
            if (en) q.push_back(e);
        end
    end

    always @(negedge clk) begin
        bit st, en, dq, il, ms;
        ent_t e;
        if (rst_n) begin
            model(st, en, dq, il, ms, e);
            chk("stall", 32'(stall_M), 32'(st));
            chk("illegal", 32'(illegal_store_M), 32'(il));
            chk("count", 32'(buf_count), q.size());
            chk("empty", 32'(buf_empty), 32'(q.size() == 0));
            chk("wvalid", 32'(mem_wvalid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("waddr", mem_waddr, q[0].a);
                chk("wdata", mem_wdata, q[0].d);
                chk("wstrb", 32'(mem_wstrb), 32'(q[0].s));
            end
`ifdef MISALIGN_CHECK_EN
            if (store_valid_M) chk("misaligned", 32'(misaligned_M), 32'(ms));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic st_set(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d);
        store_valid_M = 1'b1;
        funct3_M      = f;
        addr_M        = a;
        wdata_M       = d;
    endtask

    task automatic clr();
        store_valid_M = 1'b0;
        load_valid_M  = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_wvalid", 32'(mem_wvalid), 32'd0);
        chk("rst_count", 32'(buf_count), 32'd0);
        chk("rst_empty", 32'(buf_empty), 32'd1);
        chk("rst_waddr", mem_waddr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        #9 rst_n = 1'b1;
        step();

        st_set(3'd0, 32'h1003, 32'h000000A5);
        step();
        clr();
        chk("sb_waddr", mem_waddr, 32'h1000);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
        chk("sb_wvalid", 32'(mem_wvalid), 32'd1);
        mem_wready = 1'b1;
        step();
        chk("sb_drained", 32'(buf_empty), 32'd1);

        st_set(3'd1, 32'h2002, 32'h1234BEEF);
        step();
        clr();
        chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
        chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
        step();
        chk("sh_drained", 32'(buf_empty), 32'd1);

        mem_wready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            st_set(3'd2, 32'h100 + 32'(4 * k), 32'h11110000 + 32'(k));
            #1;
            chk("fill_stall", 32'(stall_M), 32'(k == 4));
            step();
        end
        chk("full_count", 32'(buf_count), 32'd4);
        mem_wready = 1'b1;
        #1;
        chk("full_pass", 32'(stall_M), 32'd0);
        step();
        clr();
        chk("swap_count", 32'(buf_count), 32'd4);
        chk("swap_head", mem_waddr, 32'h104);
        repeat (4) step();
        chk("fill_drained", 32'(buf_empty), 32'd1);

        mem_wready = 1'b0;
        st_set(3'd2, 32'h3000, 32'hCAFEF00D);
        step();
        clr();
        load_valid_M = 1'b1;
        addr_M       = 32'h3004;
        #1;
        chk("ld_nohit", 32'(stall_M), 32'd0);
        addr_M = 32'h3000;
        #1;
        chk("ld_hit", 32'(stall_M), 32'd1);
        step();
        chk("ld_hold", 32'(stall_M), 32'd1);
        mem_wready = 1'b1;
        #1;
        chk("ld_drain", 32'(stall_M), 32'd1);
        step();
        chk("ld_free", 32'(stall_M), 32'd0);
        clr();

        st_set(3'd3, 32'h500, 32'h1);
        #1;
        chk("ill_flag", 32'(illegal_store_M), 32'd1);
        step();
        clr();
        chk("ill_count", 32'(buf_count), 32'd0);

`ifdef MISALIGN_CHECK_EN
        st_set(3'd2, 32'h4001, 32'h7);
        #1;
        chk("mis_flag", 32'(misaligned_M), 32'd1);
        step();
        clr();
        chk("mis_count", 32'(buf_count), 32'd0);
`else
        st_set(3'd2, 32'h4001, 32'h7);
        step();
        clr();
        chk("unaligned_sw", mem_waddr, 32'h4000);
        step();
`endif

        mem_wready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            st_set(3'd2, 32'h600 + 32'(4 * k), 32'(k));
            step();
        end
        clr();
        chk("pre_rst", 32'(buf_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wvalid", 32'(mem_wvalid), 32'd0);
        chk("arst_count", 32'(buf_count), 32'd0);
        chk("arst_empty", 32'(buf_empty), 32'd1);
        #3 rst_n = 1'b1;
        step();

        repeat (80) begin
            store_valid_M = ($urandom_range(0, 2) != 0);
            load_valid_M  = !store_valid_M && ($urandom_range(0, 1) != 0);
            funct3_M      = 3'($urandom_range(0, 3));
            addr_M        = 32'h700 + 32'($urandom_range(0, 15));
            wdata_M       = $urandom;
            mem_wready    = ($urandom_range(0, 2) == 0);
            step();
        end
        clr();
        mem_wready = 1'b1;
        repeat (6) step();
        chk("end_empty", 32'(buf_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
